// File: rtl/serial_rx_9.sv
// rtl/serial_rx_9.sv - MSB-first serial-in/parallel-out receiver with 2-word output buffer
//
// Assembles WIDTH-bit words from a strobed serial stream (first bit -> Data_Out[WIDTH-1])
// and delivers them through a 2-entry FIFO with a Valid/Ready handshake.
// Optional feature macro: PARITY_CHK_EN (adds a trailing even-parity bit per word).
//
// Ports:
//   Clk       in   1      system clock, rising edge
//   Reset_n   in   1      synchronous active-low reset
//   Start     in   1      word alignment, discards any partial word
//   Shift_En  in   1      bit strobe
//   Shift_In  in   1      serial data, MSB first
//   Data_Out  out  WIDTH  head word of output buffer (0 when empty)
//   Valid     out  1      Data_Out holds a word
//   Ready     in   1      consumer pops head when Valid & Ready
//   Busy      out  1      partial word in progress
//   Overrun   out  1      sticky: completed word dropped, buffer full
//   Clr_Ovr   in   1      clears Overrun
//   Par_Err   out  1      parity error of head word (0 without PARITY_CHK_EN)
module serial_rx_9 #(
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Shift_En,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  input  logic             Ready,
  output logic             Busy,
  output logic             Overrun,
  input  logic             Clr_Ovr,
  output logic             Par_Err
);

`ifdef PARITY_CHK_EN
  localparam int NBITS = WIDTH + 1;
  localparam int EW    = WIDTH + 1;   // {par_err, data}
`else
  localparam int NBITS = WIDTH;
  localparam int EW    = WIDTH;
`endif
  // The final sampled bit never enters the shift register: it goes straight
  // into the word (or is the parity bit), so only NBITS-1 bits are held.
  localparam int SRW = NBITS - 1;
  localparam int CW  = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SRW-1:0]  sr;
  logic [1:0]      fill;
  logic [EW-1:0]   e0;
  logic [EW-1:0]   e1;
  logic            done;
  logic            pop;
  logic            accept;
  logic [EW-1:0]   new_entry;

  always_comb begin
    done   = (state == SHIFT) && Shift_En && !Start && (cnt == LAST);
    pop    = Valid && Ready;
    accept = done && ((fill != 2'd2) || pop);
  end

`ifdef PARITY_CHK_EN
  assign new_entry = {(^sr) ^ Shift_In, sr};
  assign Par_Err   = e0[WIDTH];
  assign Data_Out  = e0[WIDTH-1:0];
`else
  assign new_entry = {sr, Shift_In};
  assign Par_Err   = 1'b0;
  assign Data_Out  = e0;
`endif

  assign Valid = (fill != 2'd0);
  assign Busy  = (state == SHIFT);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      fill    <= 2'd0;
      e0      <= '0;
      e1      <= '0;
      Overrun <= 1'b0;
    end else begin
      // Bit assembly
      if (Start) begin
        state <= SHIFT;
        if (Shift_En) begin
          sr  <= SRW'(Shift_In);
          cnt <= CW'(1);
        end else begin
          sr  <= '0;
          cnt <= '0;
        end
      end else if (state == SHIFT && Shift_En) begin
        if (done) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          sr  <= SRW'({sr, Shift_In});
          cnt <= cnt + CW'(1);
        end
      end

      // Output buffer: e0 is always the head; unused slots are held at 0
      if (pop && accept) begin
        if (fill == 2'd1) begin
          e0 <= new_entry;
        end else begin
          e0 <= e1;
          e1 <= new_entry;
        end
      end else if (pop) begin
        if (fill == 2'd1) begin
          e0 <= '0;
        end else begin
          e0 <= e1;
          e1 <= '0;
        end
        fill <= fill - 2'd1;
      end else if (accept) begin
        if (fill == 2'd0) begin
          e0 <= new_entry;
        end else begin
          e1 <= new_entry;
        end
        fill <= fill + 2'd1;
      end

      // A drop in the same cycle beats the clear request
      if (done && !accept) begin
        Overrun <= 1'b1;
      end else if (Clr_Ovr) begin
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_9.sv
// tb/tb_serial_rx_9.sv - self-checking bench for serial_rx_9
module tb_serial_rx_9;
  localparam int W = 9;
`ifdef PARITY_CHK_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic         Shift_En = 1'b0;
  logic         Shift_In = 1'b0;
  logic [W-1:0] Data_Out;
  logic         Valid;
  logic         Ready = 1'b0;
  logic         Busy;
  logic         Overrun;
  logic         Clr_Ovr = 1'b0;
  logic         Par_Err;

  int checks = 0;
  int failures = 0;

  serial_rx_9 #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Shift_En(Shift_En),
    .Shift_In(Shift_In), .Data_Out(Data_Out), .Valid(Valid), .Ready(Ready),
    .Busy(Busy), .Overrun(Overrun), .Clr_Ovr(Clr_Ovr), .Par_Err(Par_Err)
  );

  always #5 Clk = ~Clk;

  // Reference model: a queue of received words plus a list of bits collected so far
  typedef struct { logic [W-1:0] w; logic pe; } ent_t;
  ent_t mq[$];
  bit   mbits[$];
  bit   mact;
  bit   movr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit en, input bit b,
                            input bit rdy, input bit clr);
    bit   pop, done, drop;
    ent_t e;
    int   ones;
    if (rst) begin
      mq.delete(); mbits.delete(); mact = 0; movr = 0;
      return;
    end
    pop = (mq.size() > 0) && rdy;
    done = 0; drop = 0;
    if (st) begin
      mbits.delete(); mact = 1;
      if (en) mbits.push_back(b);
    end else if (mact && en) begin
      mbits.push_back(b);
      if (mbits.size() == NB) begin
        e.w = '0; ones = 0;
        for (int i = 0; i < W; i++) begin
          if (mbits[i]) begin
            e.w = e.w + (W'(1) << (W - 1 - i));
            ones++;
          end
        end
`ifdef PARITY_CHK_EN
        e.pe = ((ones + int'(mbits[W])) % 2) != 0;
`else
        e.pe = 0;
`endif
        done = 1; mact = 0; mbits.delete();
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < 2) mq.push_back(e);
      else begin drop = 1; movr = 1; end
    end
    if (clr && !drop) movr = 0;
  endtask

  // One clock: drive inputs, clock, advance model, compare DUT to model
  task automatic cyc(input bit rst, input bit st, input bit en, input bit b,
                     input bit rdy, input bit clr);
    Reset_n = !rst; Start = st; Shift_En = en; Shift_In = b; Ready = rdy; Clr_Ovr = clr;
    @(posedge Clk);
    model_step(rst, st, en, b, rdy, clr);
    #1;
    chk("model_valid", Valid, mq.size() > 0);
    chk("model_data", Data_Out, (mq.size() > 0) ? mq[0].w : '0);
    chk("model_busy", Busy, mact);
    chk("model_ovr", Overrun, movr);
    chk("model_perr", Par_Err, (mq.size() > 0) ? mq[0].pe : 1'b0);
  endtask

  // Send a full word; rdy applies to all bits except the last, which uses rdy_last
  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last,
                           input bit bad_par);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < NB; i++) begin
      bit b;
      b = (i < W) ? v[W-1-i] : ((^v) ^ bad_par);
      cyc(0, i == 0, 1, b, (i == NB - 1) ? rdy_last : rdy, 0);
    end
  endtask

  typedef struct {
    bit rst, st, en, b, rdy;
    bit ev, eb;
    logic [W-1:0] ed;
  } vec_t;
  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [W-1:0] word1;
    logic [W-1:0] w0a3;

    // Vector table: reset, then 9'h1A5 MSB first, then one pop
    word1 = 9'h1A5;
    v = '{rst:1, st:0, en:0, b:0, rdy:0, ev:0, eb:0, ed:'0}; tbl.push_back(v);
    v = '{rst:1, st:1, en:1, b:1, rdy:1, ev:0, eb:0, ed:'0}; tbl.push_back(v);
    for (int i = 0; i < NB; i++) begin
      v.rst = 0; v.st = (i == 0); v.en = 1; v.rdy = 0;
      v.b  = (i < W) ? word1[W-1-i] : ^word1;
      v.ev = (i == NB - 1); v.eb = (i != NB - 1);
      v.ed = (i == NB - 1) ? word1 : '0;
      tbl.push_back(v);
    end
    v = '{rst:0, st:0, en:0, b:0, rdy:1, ev:0, eb:0, ed:'0}; tbl.push_back(v);

    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].st, tbl[k].en, tbl[k].b, tbl[k].rdy, 0);
      chk($sformatf("tbl%0d_valid", k), Valid, tbl[k].ev);
      chk($sformatf("tbl%0d_busy", k), Busy, tbl[k].eb);
      chk($sformatf("tbl%0d_data", k), Data_Out, tbl[k].ed);
      chk($sformatf("tbl%0d_ovr", k), Overrun, 1'b0);
      chk($sformatf("tbl%0d_perr", k), Par_Err, 1'b0);
    end

    // Overrun: third word dropped, order kept, Clr_Ovr clears
    send_word(9'h1A5, 0, 0, 0);
    send_word(9'h055, 0, 0, 0);
    send_word(9'h0FF, 0, 0, 0);
    chk("ovr_set", Overrun, 1'b1);
    chk("ovr_head", Data_Out, 9'h1A5);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ovr_pop1", Data_Out, 9'h055);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ovr_empty", Valid, 1'b0);
    chk("ovr_still", Overrun, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovr_clr", Overrun, 1'b0);

    // Full buffer, last bit lands together with a pop
    send_word(9'h0AA, 0, 0, 0);
    send_word(9'h133, 0, 0, 0);
    send_word(9'h100, 0, 1, 0);
    chk("fullpop_ovr", Overrun, 1'b0);
    chk("fullpop_head", Data_Out, 9'h133);
    cyc(0, 0, 0, 0, 1, 0);
    chk("fullpop_next", Data_Out, 9'h100);
    cyc(0, 0, 0, 0, 1, 0);
    chk("fullpop_empty", Valid, 1'b0);
    chk("fullpop_data0", Data_Out, 9'h000);

    // Realignment: 4 stray bits, then Start+Shift_En begins 9'h0A3
    w0a3 = 9'h0A3;
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < NB; i++)
      cyc(0, i == 0, 1, (i < W) ? w0a3[W-1-i] : ^w0a3, 0, 0);
    chk("realign_valid", Valid, 1'b1);
    chk("realign_data", Data_Out, 9'h0A3);
    chk("realign_busy", Busy, 1'b0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0);
    chk("idle_busy", Busy, 1'b0);
    chk("idle_data", Data_Out, 9'h0A3);
    cyc(0, 0, 0, 0, 1, 0);
    chk("idle_nonew", Valid, 1'b0);

    // Reset mid-word with two words buffered
    send_word(9'h011, 0, 0, 0);
    send_word(9'h122, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("pre_rst_busy", Busy, 1'b1);
    cyc(1, 0, 1, 1, 1, 0);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_data", Data_Out, 9'h000);

`ifdef PARITY_CHK_EN
    send_word(9'h1A5, 0, 0, 1);
    chk("par_bad", Par_Err, 1'b1);
    chk("par_bad_data", Data_Out, 9'h1A5);
    cyc(0, 0, 0, 0, 1, 0);
`endif

    // Randomized phase against the model
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
